multicycle_control_unit: RTL and testbench

Moore-style controller that sequences the multicycle MIPS datapath. It reads `OP`/`Funct` from the datapath's instruction register and `Zero` from its ALU, then drives every datapath control strobe cycle by cycle through fetch, decode, execute, memory and write-back. It sits beside the datapath in the processor top level and is the only source of the datapath's control inputs.

---
 rtl/mcu_pkg.sv | 48 ++++
 rtl/alu_decoder.sv | 35 +++
 rtl/multicycle_control_unit.sv | 142 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle MIPS controller and datapath ALU:
// FSM state encoding, opcode/Funct constants and ALUControl codes.
package mcu_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10
  } state_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctNor = 6'b100111;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  // States whose successor is FETCH with a completed instruction.
  function automatic logic is_terminal(state_t s);
    case (s)
      StMemWb, StMemWr, StAluWb, StAddiWb, StBranch: is_terminal = 1'b1;
      default:                                       is_terminal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select: fixed ops per state, Funct decode in EXEC.
module alu_decoder
  import mcu_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_control_o   = AluAnd;
    funct_illegal_o = 1'b0;
    case (state_i)
      StFetch, StDecode, StMemAdr, StAddiEx: alu_control_o = AluAdd;
      StBranch:                              alu_control_o = AluSub;
      StExec: begin
        case (funct_i)
          FunctAdd: alu_control_o = AluAdd;
          FunctSub: alu_control_o = AluSub;
          FunctAnd: alu_control_o = AluAnd;
          FunctOr:  alu_control_o = AluOr;
          FunctNor: alu_control_o = AluNor;
          FunctSlt: alu_control_o = AluSlt;
          default: begin
            alu_control_o   = AluAdd;
            funct_illegal_o = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore controller for the multicycle MIPS datapath with a retired-instruction counter.
// Define CTRL_BNE_EN to decode opcode 000101 as BNE; otherwise it is illegal.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 PCSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUControl,
  output logic [3:0]           state_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] retired_o
);

  state_t               state_q, state_d, state_eff;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 op_illegal, funct_illegal, branch_take;
  logic                 pc_write, mem_write, ir_write, reg_write;

  // Outputs show FETCH values while reset is held, whatever the register holds.
  assign state_eff = reset ? StFetch : state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (is_terminal(state_q)) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d    = StFetch;
    op_illegal = 1'b0;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (OP)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
`ifdef CTRL_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          default: begin
            state_d    = StFetch;
            op_illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (OP == OpSw) ? StMemWr : StMemRd;
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

`ifdef CTRL_BNE_EN
  assign branch_take = (OP == OpBne) ? ~Zero : Zero;
`else
  assign branch_take = Zero;
`endif

  always_comb begin
    pc_write  = 1'b0;
    IorD      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    reg_write = 1'b0;
    PCSrc     = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (state_eff)
      StFetch: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        ALUSrcB  = 2'b01;
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr, StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: IorD = 1'b1;
      StMemWr: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      StMemWb: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
      end
      StExec: ALUSrcA = 1'b1;
      StAluWb: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
      end
      StAddiWb: reg_write = 1'b1;
      StBranch: begin
        ALUSrcA  = 1'b1;
        PCSrc    = 1'b1;
        pc_write = branch_take;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .state_i         (state_eff),
    .funct_i         (Funct),
    .alu_control_o   (ALUControl),
    .funct_illegal_o (funct_illegal)
  );

  assign PCWrite   = pc_write & ~reset;
  assign MemWrite  = mem_write & ~reset;
  assign IRWrite   = ir_write & ~reset;
  assign RegWrite  = reg_write & ~reset;
  assign illegal_o = ~reset & (op_illegal | funct_illegal);
  assign state_o   = state_eff;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations, a negedge
// monitor pops and compares them against the controller outputs.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP, Funct;
  logic       Zero;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCSrc, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl, state_o;
  logic       illegal_o;
  logic [3:0] retired_o;

  multicycle_control_unit #(.CNT_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .OP         (OP),
    .Funct      (Funct),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .PCSrc      (PCSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .state_o    (state_o),
    .illegal_o  (illegal_o),
    .retired_o  (retired_o)
  );

  always #5 clk = ~clk;

  // ctrl = {PCWrite,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,PCSrc,ALUSrcA,ALUSrcB,ALUControl}
  localparam logic [14:0] C_FETCH  = {9'b100100000, 2'b01, 4'b0010};
  localparam logic [14:0] C_FRST   = {9'b000000000, 2'b01, 4'b0010};
  localparam logic [14:0] C_DECODE = {9'b000000000, 2'b11, 4'b0010};
  localparam logic [14:0] C_MEMADR = {9'b000000001, 2'b10, 4'b0010};
  localparam logic [14:0] C_MEMRD  = {9'b010000000, 2'b00, 4'b0000};
  localparam logic [14:0] C_MEMWR  = {9'b011000000, 2'b00, 4'b0000};
  localparam logic [14:0] C_MEMWB  = {9'b000001100, 2'b00, 4'b0000};
  localparam logic [14:0] C_ALUWB  = {9'b000010100, 2'b00, 4'b0000};
  localparam logic [14:0] C_ADDIWB = {9'b000000100, 2'b00, 4'b0000};
  localparam logic [14:0] C_BR_T   = {9'b100000011, 2'b00, 4'b0110};
  localparam logic [14:0] C_BR_N   = {9'b000000011, 2'b00, 4'b0110};

  typedef struct packed {
    logic        chk_state;
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic        ill;
    logic [3:0]  ret;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] r;

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      if (m.chk_state) chk("state", {11'b0, state_o}, {11'b0, m.st});
      chk("ctrl", {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCSrc,
                   ALUSrcA, ALUSrcB, ALUControl}, m.ctrl);
      chk("illegal", {14'b0, illegal_o}, {14'b0, m.ill});
      chk("retired", {11'b0, retired_o}, {11'b0, m.ret});
    end
  end

  task automatic step(input logic [3:0] st, input logic [14:0] ctl, input logic ill,
                      input logic cs);
    exp_t e;
    e.chk_state = cs;
    e.st        = st;
    e.ctrl      = ctl;
    e.ill       = ill;
    e.ret       = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    OP    = op;
    Funct = fn;
    Zero  = z;
    step(4'd0, C_FETCH, 1'b0, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 1'b1);
  endtask

  task automatic do_lw();
    begin_instr(6'b100011, 6'b0, 1'b0);
    step(4'd2, C_MEMADR, 1'b0, 1'b1);
    step(4'd3, C_MEMRD, 1'b0, 1'b1);
    step(4'd4, C_MEMWB, 1'b0, 1'b1);
    r = r + 4'd1;
  endtask

  task automatic do_sw();
    begin_instr(6'b101011, 6'b0, 1'b0);
    step(4'd2, C_MEMADR, 1'b0, 1'b1);
    step(4'd5, C_MEMWR, 1'b0, 1'b1);
    r = r + 4'd1;
  endtask

  task automatic do_rtype(input logic [5:0] fn, input logic [3:0] aluc, input logic ill);
    begin_instr(6'b000000, fn, 1'b0);
    step(4'd6, {9'b000000001, 2'b00, aluc}, ill, 1'b1);
    step(4'd7, C_ALUWB, 1'b0, 1'b1);
    r = r + 4'd1;
  endtask

  task automatic do_addi();
    begin_instr(6'b001000, 6'b0, 1'b0);
    step(4'd9, C_MEMADR, 1'b0, 1'b1);
    step(4'd10, C_ADDIWB, 1'b0, 1'b1);
    r = r + 4'd1;
  endtask

  task automatic do_branch(input logic [5:0] op, input logic z, input logic [14:0] ctl);
    begin_instr(op, 6'b0, z);
    step(4'd8, ctl, 1'b0, 1'b1);
    r = r + 4'd1;
  endtask

  task automatic do_illegal(input logic [5:0] op);
    OP    = op;
    Funct = 6'b0;
    Zero  = 1'b0;
    step(4'd0, C_FETCH, 1'b0, 1'b1);
    step(4'd1, C_DECODE, 1'b1, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    OP    = 6'b0;
    Funct = 6'b0;
    Zero  = 1'b0;
    r     = 4'd0;
    @(posedge clk);
    #1;
    repeat (3) step(4'd0, C_FRST, 1'b0, 1'b1);
    reset = 1'b0;

    do_lw();
    do_sw();
    do_rtype(6'b100010, 4'b0110, 1'b0);
    do_rtype(6'b111111, 4'b0010, 1'b1);
    do_rtype(6'b100000, 4'b0010, 1'b0);
    do_rtype(6'b100100, 4'b0000, 1'b0);
    do_rtype(6'b100101, 4'b0001, 1'b0);
    do_rtype(6'b100111, 4'b1100, 1'b0);
    do_rtype(6'b101010, 4'b0111, 1'b0);
    do_addi();
    do_branch(6'b000100, 1'b1, C_BR_T);
    do_branch(6'b000100, 1'b0, C_BR_N);
`ifdef CTRL_BNE_EN
    do_branch(6'b000101, 1'b0, C_BR_T);
    do_branch(6'b000101, 1'b1, C_BR_N);
`else
    do_illegal(6'b000101);
`endif
    do_illegal(6'b111111);

    // Reset arrives while in MEMWR: no write strobe that cycle, FETCH after the edge.
    begin_instr(6'b101011, 6'b0, 1'b0);
    step(4'd2, C_MEMADR, 1'b0, 1'b1);
    reset = 1'b1;
    step(4'd5, C_FRST, 1'b0, 1'b0);
    reset = 1'b0;
    r = 4'd0;

    // Sixteen retires walk the 4-bit counter through 15 and wrap to 0.
    repeat (16) do_addi();
    OP = 6'b0;
    step(4'd0, C_FETCH, 1'b0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 15'(sb.size()), 15'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
